// File: rtl/bjk_rom_loader.sv
// rtl/bjk_rom_loader.sv - HPS ioctl ROM download sequencer for the Bomb Jack core
// Splits the linear image into main/sound/gfx/PROM regions, validates it and gates core reset.
module bjk_rom_loader #(
    parameter logic [16:0] R1_BASE    = 17'h0E000,
    parameter logic [16:0] R2_BASE    = 17'h10000,
    parameter logic [16:0] R3_BASE    = 17'h1C000,
    parameter logic [17:0] TOTAL_LEN  = 18'h1C100,
    parameter int          RESET_HOLD = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [3:0]  dn_wr,
    output logic        core_reset,
    output logic        rom_ok,
    output logic        err_short,
    output logic        err_overflow,
    output logic [17:0] byte_count,
    output logic [7:0]  checksum
);

    localparam int HW = $clog2(RESET_HOLD + 1);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, HOLD, RUN, ERROR} state_t;

    state_t        state;
    state_t        state_next;
    logic          dl_prev;
    logic [HW-1:0] hold_cnt;
    logic          rise;
    logic          fall;
    logic          wr_in_range;
    logic          accept;
    logic          overflow_wr;
    logic [16:0]   addr17;
    logic [16:0]   region_base;
    logic [3:0]    region_sel;

    // dl_prev resets high so a download already running at reset release is not a start
    assign rise        = ioctl_download & ~dl_prev;
    assign fall        = ~ioctl_download & dl_prev;
    assign wr_in_range = ioctl_addr < {7'd0, TOTAL_LEN};
    assign accept      = (state == LOAD) && ioctl_wr && wr_in_range;
    assign overflow_wr = (state == LOAD) && ioctl_wr && !wr_in_range;
    assign addr17      = ioctl_addr[16:0];

    always_comb begin
        region_sel  = 4'b0001;
        region_base = '0;
        if (addr17 >= R3_BASE) begin
            region_sel  = 4'b1000;
            region_base = R3_BASE;
        end else if (addr17 >= R2_BASE) begin
            region_sel  = 4'b0100;
            region_base = R2_BASE;
        end else if (addr17 >= R1_BASE) begin
            region_sel  = 4'b0010;
            region_base = R1_BASE;
        end
    end

    always_comb begin
        state_next = state;
        if (rise) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (fall) state_next = CHECK;
                CHECK:   state_next = (byte_count == TOTAL_LEN && !err_overflow) ? HOLD : ERROR;
                HOLD:    if (hold_cnt == HW'(RESET_HOLD - 1)) state_next = RUN;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            dl_prev      <= 1'b1;
            hold_cnt     <= '0;
            dn_addr      <= '0;
            dn_data      <= '0;
            dn_wr        <= '0;
            core_reset   <= 1'b1;
            rom_ok       <= 1'b0;
            err_short    <= 1'b0;
            err_overflow <= 1'b0;
            byte_count   <= '0;
            checksum     <= '0;
        end else begin
            state      <= state_next;
            dl_prev    <= ioctl_download;
            core_reset <= (state_next != RUN);
            hold_cnt   <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
            dn_wr      <= accept ? region_sel : 4'b0000;
            if (accept) begin
                dn_addr <= addr17 - region_base;
                dn_data <= ioctl_dout;
            end
            if (rise) begin
                rom_ok       <= 1'b0;
                err_short    <= 1'b0;
                err_overflow <= 1'b0;
                byte_count   <= '0;
                checksum     <= '0;
            end else begin
                if (accept) begin
                    if (byte_count != '1) byte_count <= byte_count + 18'd1;
                    checksum <= checksum + ioctl_dout;
                end
                if (overflow_wr) err_overflow <= 1'b1;
                if (state == CHECK) begin
                    rom_ok    <= (byte_count == TOTAL_LEN) && !err_overflow;
                    err_short <= (byte_count != TOTAL_LEN);
                end
            end
        end
    end

endmodule
